// File: rtl/bidimen_pkg.sv
// bidimen_pkg: shared width helpers and output-buffer state encoding for the bidimensional mux family
package bidimen_pkg;
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
    function automatic int sel_width(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
    function automatic int total_bits(input int width, input int depth);
        return width * depth;
    endfunction
endpackage

// File: rtl/bidimen_mux_arb_if.sv
// bidimen_mux_arb_if: requester bus plus output handshake; s_last exists only with BIDIMEN_ARB_LOCK_EN
interface bidimen_mux_arb_if import bidimen_pkg::*; #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
);
    localparam int SEL_WIDTH  = sel_width(DEPTH);
    localparam int TOTAL_BITS = total_bits(WIDTH, DEPTH);
    logic [DEPTH-1:0]      s_valid;
    logic [TOTAL_BITS-1:0] s_data;
    logic [DEPTH-1:0]      s_ready;
    logic                  m_valid;
    logic [WIDTH-1:0]      m_data;
    logic [SEL_WIDTH-1:0]  m_sel;
    logic                  m_ready;
`ifdef BIDIMEN_ARB_LOCK_EN
    logic [DEPTH-1:0]      s_last;
    modport master (output s_valid, s_data, s_last, m_ready, input s_ready, m_valid, m_data, m_sel);
    modport slave  (input s_valid, s_data, s_last, m_ready, output s_ready, m_valid, m_data, m_sel);
`else
    modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, m_sel);
    modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_sel);
`endif
endinterface

// File: rtl/bidimen_mux.sv
// bidimen_mux: selects one WIDTH-bit word out of a packed DEPTH x WIDTH bus
module bidimen_mux import bidimen_pkg::*; #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int SEL_WIDTH  = sel_width(DEPTH),
    localparam int TOTAL_BITS = total_bits(WIDTH, DEPTH)
) (
    input  logic [TOTAL_BITS-1:0] m_in,
    input  logic [SEL_WIDTH-1:0]  m_ctrl,
    output logic [WIDTH-1:0]      m_out
);
    // Explicit compare loop keeps out-of-range selects at zero for non-power-of-2 DEPTH
    always_comb begin
        m_out = '0;
        for (int i = 0; i < DEPTH; i++)
            if (m_ctrl == SEL_WIDTH'(i)) m_out = m_in[i*WIDTH +: WIDTH];
    end
endmodule

// File: rtl/bidimen_mux_arb.sv
// bidimen_mux_arb: round-robin arbiter feeding bidimen_mux into a one-entry output buffer
// BIDIMEN_ARB_LOCK_EN: hold the grant on one requester until its s_last beat
module bidimen_mux_arb import bidimen_pkg::*; #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic arst_n,
    bidimen_mux_arb_if.slave bus
);
    localparam int SEL_WIDTH = sel_width(DEPTH);

    function automatic logic [SEL_WIDTH-1:0] rr_pick(input logic [DEPTH-1:0] v, input logic [SEL_WIDTH-1:0] p);
        logic [SEL_WIDTH-1:0] lo, hi;
        logic hf;
        lo = '0;
        hi = '0;
        hf = 1'b0;
        // Descending scan leaves the lowest match; hi covers indices at or above the pointer
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v[i]) lo = SEL_WIDTH'(i);
            if (v[i] && SEL_WIDTH'(i) >= p) begin
                hi = SEL_WIDTH'(i);
                hf = 1'b1;
            end
        end
        return hf ? hi : lo;
    endfunction

    state_t               state;
    logic [WIDTH-1:0]     data_q, mux_out;
    logic [SEL_WIDTH-1:0] sel_q, rr_ptr, winner, rr_next;
    logic [DEPTH-1:0]     req;
    logic                 accept, grant;

`ifdef BIDIMEN_ARB_LOCK_EN
    logic                 locked;
    logic [SEL_WIDTH-1:0] lock_idx;
    assign req = locked ? bus.s_valid & (DEPTH'(1) << lock_idx) : bus.s_valid;
`else
    assign req = bus.s_valid;
`endif

    assign winner      = rr_pick(req, rr_ptr);
    assign rr_next     = (winner == SEL_WIDTH'(DEPTH - 1)) ? '0 : winner + 1'b1;
    assign accept      = (state == ST_EMPTY) | bus.m_ready;
    assign grant       = accept & (|req);
    assign bus.s_ready = (grant & arst_n) ? DEPTH'(1) << winner : '0;
    assign bus.m_valid = (state == ST_FULL);
    assign bus.m_data  = data_q;
    assign bus.m_sel   = sel_q;

    bidimen_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mux (
        .m_in   (bus.s_data),
        .m_ctrl (winner),
        .m_out  (mux_out)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= ST_EMPTY;
            data_q <= '0;
            sel_q  <= '0;
            rr_ptr <= '0;
`ifdef BIDIMEN_ARB_LOCK_EN
            locked   <= 1'b0;
            lock_idx <= '0;
`endif
        end else if (grant) begin
            state  <= ST_FULL;
            data_q <= mux_out;
            sel_q  <= winner;
`ifdef BIDIMEN_ARB_LOCK_EN
            locked   <= !bus.s_last[winner];
            lock_idx <= winner;
            if (bus.s_last[winner]) rr_ptr <= rr_next;
`else
            rr_ptr <= rr_next;
`endif
        end else if (bus.m_ready) begin
            state <= ST_EMPTY;
        end
    end
endmodule

// File: tb/tb_bidimen_mux_arb.sv
// tb_bidimen_mux_arb: directed checks of arbitration order, handshakes, reset and packet lock
module tb_bidimen_mux_arb;
    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic arst_n;
    int checks = 0;
    int errors = 0;

    bidimen_mux_arb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    bidimen_mux_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic apply_reset;
        arst_n = 1'b0;
        bus.s_valid = '0;
        bus.s_data = '0;
        bus.m_ready = 1'b0;
`ifdef BIDIMEN_ARB_LOCK_EN
        bus.s_last = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_reset;
        arst_n = 1'b0;
`ifdef BIDIMEN_ARB_LOCK_EN
        bus.s_last = '1;
`endif
        bus.s_valid = 4'b1111;
        bus.s_data = 8'b11100100;
        bus.m_ready = 1'b1;
        #1;
        checks++;
        if (bus.s_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", bus.s_ready); end
        checks++;
        if ({bus.m_valid, bus.m_data, bus.m_sel} !== 5'b0) begin errors++; $display("FAIL reset_out got v%b d%b s%0d want all 0", bus.m_valid, bus.m_data, bus.m_sel); end
        @(negedge clk);
        arst_n = 1'b1;
        bus.s_valid = 4'b0100;
        bus.m_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_sel !== 2'd2 || bus.m_data !== 2'd2) begin errors++; $display("FAIL reset_load got v%b d%b s%0d want v1 d10 s2", bus.m_valid, bus.m_data, bus.m_sel); end
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", bus.m_valid); end
        checks++;
        if (bus.m_data !== 2'd0 || bus.m_sel !== 2'd0) begin errors++; $display("FAIL async_out got d%b s%0d want d00 s0", bus.m_data, bus.m_sel); end
        checks++;
        if (bus.s_ready !== 4'b0000) begin errors++; $display("FAIL async_ready got %b want 0000", bus.s_ready); end
        @(negedge clk);
        arst_n = 1'b1;
        bus.s_valid = 4'b1111;
        #1;
        checks++;
        if (bus.s_ready !== 4'b0001) begin errors++; $display("FAIL post_reset_ready got %b want 0001", bus.s_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_sel !== 2'd0 || bus.m_data !== 2'd0) begin errors++; $display("FAIL post_reset_grant got v%b d%b s%0d want v1 d00 s0", bus.m_valid, bus.m_data, bus.m_sel); end
    endtask

    task automatic test_round_robin;
        logic [1:0] e;
        apply_reset();
        bus.s_data = 8'b11100100;
        bus.s_valid = 4'b1111;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e = 2'(i % 4);
            #1;
            checks++;
            if (bus.s_ready !== (4'b0001 << e)) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", i, bus.s_ready, 4'b0001 << e); end
            @(posedge clk);
            #1;
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_sel !== e || bus.m_data !== e) begin errors++; $display("FAIL rr_out[%0d] got v%b d%b s%0d want v1 d%b s%0d", i, bus.m_valid, bus.m_data, bus.m_sel, e, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        apply_reset();
        bus.s_valid = 4'b0100;
        bus.s_data = 8'b00100000;
        #1;
        checks++;
        if (bus.s_ready !== 4'b0100) begin errors++; $display("FAIL bp_first_ready got %b want 0100", bus.s_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 2'b10 || bus.m_sel !== 2'd2) begin errors++; $display("FAIL bp_load got v%b d%b s%0d want v1 d10 s2", bus.m_valid, bus.m_data, bus.m_sel); end
        @(negedge clk);
        bus.s_data = 8'b00010000;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.s_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0000", i, bus.s_ready); end
            @(posedge clk);
            #1;
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== 2'b10) begin errors++; $display("FAIL bp_hold[%0d] got v%b d%b want v1 d10", i, bus.m_valid, bus.m_data); end
            @(negedge clk);
        end
        bus.m_ready = 1'b1;
        #1;
        checks++;
        if (bus.s_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b want 0100", bus.s_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 2'b01 || bus.m_sel !== 2'd2) begin errors++; $display("FAIL bp_replace got v%b d%b s%0d want v1 d01 s2", bus.m_valid, bus.m_data, bus.m_sel); end
        @(negedge clk);
    endtask

    task automatic test_drain;
        bus.s_valid = 4'b0000;
        bus.m_ready = 1'b1;
        #1;
        checks++;
        if (bus.s_ready !== 4'b0000) begin errors++; $display("FAIL drain_ready got %b want 0000", bus.s_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.m_sel !== 2'd2 || bus.m_data !== 2'b01) begin errors++; $display("FAIL drain_out got v%b d%b s%0d want v0 d01 s2", bus.m_valid, bus.m_data, bus.m_sel); end
        @(negedge clk);
        bus.m_ready = 1'b0;
        bus.s_valid = 4'b0001;
        bus.s_data = 8'b00000011;
        #1;
        checks++;
        if (bus.s_ready !== 4'b0001) begin errors++; $display("FAIL empty_accept got %b want 0001", bus.s_ready); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_sel !== 2'd0 || bus.m_data !== 2'b11) begin errors++; $display("FAIL empty_load got v%b d%b s%0d want v1 d11 s0", bus.m_valid, bus.m_data, bus.m_sel); end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        logic [1:0] es [3];
        logic [1:0] ed [3];
        es = '{2'd0, 2'd1, 2'd0};
        ed = '{2'b01, 2'b10, 2'b01};
        apply_reset();
        bus.m_ready = 1'b1;
        bus.s_valid = 4'b0100;
        @(negedge clk);
        bus.s_valid = 4'b0011;
        bus.s_data = 8'b00001001;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.s_ready !== (4'b0001 << es[i])) begin errors++; $display("FAIL wrap_ready[%0d] got %b want %b", i, bus.s_ready, 4'b0001 << es[i]); end
            @(posedge clk);
            #1;
            checks++;
            if (bus.m_sel !== es[i] || bus.m_data !== ed[i]) begin errors++; $display("FAIL wrap_out[%0d] got d%b s%0d want d%b s%0d", i, bus.m_data, bus.m_sel, ed[i], es[i]); end
            @(negedge clk);
        end
    endtask

`ifdef BIDIMEN_ARB_LOCK_EN
    task automatic test_lock;
        logic [3:0] vv [6];
        logic [3:0] ll [6];
        logic [3:0] er [6];
        logic       ev [6];
        vv = '{4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0110, 4'b0100};
        ll = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        er = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0100};
        ev = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        apply_reset();
        bus.m_ready = 1'b1;
        bus.s_data = 8'b00100100;
        for (int i = 0; i < 6; i++) begin
            bus.s_valid = vv[i];
            bus.s_last = ll[i];
            #1;
            checks++;
            if (bus.s_ready !== er[i]) begin errors++; $display("FAIL lock_ready[%0d] got %b want %b", i, bus.s_ready, er[i]); end
            @(posedge clk);
            #1;
            checks++;
            if (bus.m_valid !== ev[i] || (ev[i] && bus.m_sel !== (er[i] == 4'b0100 ? 2'd2 : 2'd1))) begin errors++; $display("FAIL lock_out[%0d] got v%b s%0d want v%b", i, bus.m_valid, bus.m_sel, ev[i]); end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_drain();
        test_wrap();
`ifdef BIDIMEN_ARB_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
